// File: rtl/ucie_rdi_pkg.sv
// Shared encodings for the RDI physical-layer responder.
// State-status and adapter request codes plus the FSM state type.
package ucie_rdi_pkg;

    localparam logic [3:0] STS_RESET     = 4'b0000;
    localparam logic [3:0] STS_ACTIVE    = 4'b0001;
    localparam logic [3:0] STS_LINKRESET = 4'b1001;
    localparam logic [3:0] STS_LINKERROR = 4'b1010;
    localparam logic [3:0] STS_RETRAIN   = 4'b1011;
    localparam logic [3:0] STS_DISABLED  = 4'b1100;

    localparam logic [3:0] REQ_NOP       = 4'b0000;
    localparam logic [3:0] REQ_ACTIVE    = 4'b0001;
    localparam logic [3:0] REQ_L1        = 4'b0100;
    localparam logic [3:0] REQ_LINKRESET = 4'b1001;
    localparam logic [3:0] REQ_RETRAIN   = 4'b1011;
    localparam logic [3:0] REQ_DISABLED  = 4'b1100;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_TRAIN,
        ST_ACTIVE,
        ST_RETRAIN,
        ST_LINKRESET,
        ST_LINKERROR,
        ST_DISABLED
    } rdi_state_e;

    // TRAIN is invisible to the adapter and reports Reset.
    function automatic logic [3:0] state_sts(rdi_state_e s);
        logic [3:0] r;
        r = STS_RESET;
        case (s)
            ST_ACTIVE:    r = STS_ACTIVE;
            ST_RETRAIN:   r = STS_RETRAIN;
            ST_LINKRESET: r = STS_LINKRESET;
            ST_LINKERROR: r = STS_LINKERROR;
            ST_DISABLED:  r = STS_DISABLED;
            default:      r = STS_RESET;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ucie_rdi_if.sv
// RDI signal bundle between adapter (master) and PHY side (slave).
// lp_* flow adapter to PHY, pl_* flow PHY to adapter.
interface ucie_rdi_if;

    logic [3:0] lp_state_req;
    logic       lp_linkerror;
    logic [3:0] pl_state_sts;
    logic       pl_inband_pres;
    logic [2:0] pl_speedmode;
    logic [2:0] pl_lnk_cfg;
    logic       pl_phyinrecenter;
    logic       pl_trainerror;
    logic       pl_error;

    modport master (
        output lp_state_req,
        output lp_linkerror,
        input  pl_state_sts,
        input  pl_inband_pres,
        input  pl_speedmode,
        input  pl_lnk_cfg,
        input  pl_phyinrecenter,
        input  pl_trainerror,
        input  pl_error
    );

    modport slave (
        input  lp_state_req,
        input  lp_linkerror,
        output pl_state_sts,
        output pl_inband_pres,
        output pl_speedmode,
        output pl_lnk_cfg,
        output pl_phyinrecenter,
        output pl_trainerror,
        output pl_error
    );

endinterface

// File: rtl/ucie_rdi_timer.sv
// Loadable down-counter shared by TRAIN, RETRAIN and LINKRESET.
// Done flags the last counted cycle; it parks at zero, never wraps.
module ucie_rdi_timer #(
    parameter int W = 7
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_done
);

    logic [W-1:0] cnt;

    // Load has priority; otherwise count down and stop at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_load) begin
            cnt <= i_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign o_done = (cnt == W'(1)) && !i_load;

endmodule

// File: rtl/ucie_rdi_pl_responder.sv
// RDI physical-layer-side state responder standing in for the PHY.
// Turns adapter requests and PHY events into registered pl_* status.
module ucie_rdi_pl_responder
    import ucie_rdi_pkg::*;
#(
    parameter int TRAIN_CYCLES   = 64,
    parameter int RETRAIN_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    ucie_rdi_if.slave  rdi,
    input  logic       i_phy_start,
    input  logic       i_phy_train_fail,
    input  logic       i_phy_recenter,
    input  logic [2:0] i_cfg_speedmode,
    input  logic [2:0] i_cfg_lnk_cfg
);

    localparam int MAXC = (TRAIN_CYCLES > RETRAIN_CYCLES)
                        ? TRAIN_CYCLES : RETRAIN_CYCLES;
    localparam int TW = $clog2(MAXC + 1);
    localparam logic [TW-1:0] TRAIN_VAL = TW'(TRAIN_CYCLES);
    localparam logic [TW-1:0] RETR_VAL  = TW'(RETRAIN_CYCLES);

    rdi_state_e    state;
    rdi_state_e    state_n;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;

    logic [3:0] sts_q;
    logic       pres_q;
    logic [2:0] spd_q;
    logic [2:0] lnk_q;
    logic       rc_q;
    logic       terr_q;
    logic       err_q;

    logic [3:0] sts_n;
    logic       pres_n;
    logic [2:0] spd_n;
    logic [2:0] lnk_n;
    logic       rc_n;
    logic       terr_n;
    logic       err_n;

    logic [3:0] req;
    logic       lerr;

    assign req  = rdi.lp_state_req;
    assign lerr = rdi.lp_linkerror;

    ucie_rdi_timer #(.W(TW)) u_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (tmr_load),
        .i_val  (tmr_val),
        .o_done (tmr_done)
    );

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_RESET;
            sts_q  <= STS_RESET;
            pres_q <= 1'b0;
            spd_q  <= '0;
            lnk_q  <= '0;
            rc_q   <= 1'b0;
            terr_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            sts_q  <= sts_n;
            pres_q <= pres_n;
            spd_q  <= spd_n;
            lnk_q  <= lnk_n;
            rc_q   <= rc_n;
            terr_q <= terr_n;
            err_q  <= err_n;
        end
    end

    // Next state; a link error outranks every other event.
    always_comb begin
        state_n  = state;
        tmr_load = 1'b0;
        tmr_val  = TRAIN_VAL;
        if (state != ST_LINKERROR && lerr) begin
            state_n = ST_LINKERROR;
        end else begin
            unique case (state)
                ST_RESET: begin
                    if (i_phy_start) begin
                        state_n  = ST_TRAIN;
                        tmr_load = 1'b1;
                    end else if (pres_q && req == REQ_ACTIVE) begin
                        state_n = ST_ACTIVE;
                    end
                end
                ST_TRAIN: begin
                    if (i_phy_train_fail) begin
                        state_n = ST_LINKERROR;
                    end else if (tmr_done) begin
                        state_n = ST_RESET;
                    end
                end
                ST_ACTIVE: begin
                    if (req == REQ_RETRAIN || i_phy_recenter) begin
                        state_n  = ST_RETRAIN;
                        tmr_load = 1'b1;
                        tmr_val  = RETR_VAL;
                    end else if (req == REQ_LINKRESET) begin
                        state_n  = ST_LINKRESET;
                        tmr_load = 1'b1;
                        tmr_val  = RETR_VAL;
                    end else if (req == REQ_DISABLED) begin
                        state_n = ST_DISABLED;
                    end
                end
                ST_RETRAIN: begin
                    if (!rc_q && req == REQ_ACTIVE) begin
                        state_n = ST_ACTIVE;
                    end
                end
                ST_LINKRESET: begin
                    if (tmr_done) begin
                        state_n = ST_RESET;
                    end
                end
                ST_DISABLED: begin
                    if (i_phy_start) begin
                        state_n  = ST_TRAIN;
                        tmr_load = 1'b1;
                    end
                end
                ST_LINKERROR: begin
                    if (!lerr && req == REQ_ACTIVE) begin
                        state_n = ST_RESET;
                    end
                end
                default: state_n = ST_RESET;
            endcase
        end
    end

    // Next output values, derived from the transition being taken.
    always_comb begin
        sts_n  = state_sts(state_n);
        pres_n = pres_q;
        spd_n  = spd_q;
        lnk_n  = lnk_q;
        rc_n   = rc_q;
        terr_n = 1'b0;
        err_n  = 1'b0;
        if (state == ST_TRAIN && state_n == ST_RESET) begin
            pres_n = 1'b1;
            spd_n  = i_cfg_speedmode;
            lnk_n  = i_cfg_lnk_cfg;
        end
        if (state == ST_LINKRESET && state_n == ST_RESET) begin
            pres_n = 1'b0;
        end
        if (state == ST_DISABLED && state_n == ST_TRAIN) begin
            pres_n = 1'b0;
        end
        if (state_n == ST_LINKERROR) begin
            pres_n = 1'b0;
            err_n  = (state != ST_LINKERROR);
        end
        if (state == ST_TRAIN && !lerr && i_phy_train_fail) begin
            terr_n = 1'b1;
        end
        if (state_n != ST_RETRAIN) begin
            rc_n = 1'b0;
        end else if (state != ST_RETRAIN) begin
            rc_n = 1'b1;
        end else if (tmr_done) begin
            rc_n = 1'b0;
        end
    end

    assign rdi.pl_state_sts     = sts_q;
    assign rdi.pl_inband_pres   = pres_q;
    assign rdi.pl_speedmode     = spd_q;
    assign rdi.pl_lnk_cfg       = lnk_q;
    assign rdi.pl_phyinrecenter = rc_q;
    assign rdi.pl_trainerror    = terr_q;
    assign rdi.pl_error         = err_q;

endmodule

// File: tb/tb_ucie_rdi_pl_responder.sv
// Bench for the RDI PL responder: directed scenarios then random traffic.
// A cycle-level reference model built from the link rules tracks outputs.
module tb_ucie_rdi_pl_responder;
    import ucie_rdi_pkg::*;

    localparam int TC = 64;
    localparam int RC = 16;

    localparam int M_RST = 0;
    localparam int M_TR  = 1;
    localparam int M_ACT = 2;
    localparam int M_RT  = 3;
    localparam int M_LR  = 4;
    localparam int M_LE  = 5;
    localparam int M_DIS = 6;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       start = 1'b0;
    logic       fail  = 1'b0;
    logic       rec   = 1'b0;
    logic [2:0] cfg_spd = '0;
    logic [2:0] cfg_lnk = '0;

    int vectors = 0;
    int miscompares = 0;

    int         m_mode = M_RST;
    int         m_left = 0;
    bit         m_pres = 0;
    bit         m_rc   = 0;
    bit         m_terr = 0;
    bit         m_err  = 0;
    logic [2:0] m_spd  = '0;
    logic [2:0] m_lnk  = '0;

    ucie_rdi_if rdi ();

    ucie_rdi_pl_responder #(
        .TRAIN_CYCLES   (TC),
        .RETRAIN_CYCLES (RC)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .rdi              (rdi.slave),
        .i_phy_start      (start),
        .i_phy_train_fail (fail),
        .i_phy_recenter   (rec),
        .i_cfg_speedmode  (cfg_spd),
        .i_cfg_lnk_cfg    (cfg_lnk)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [3:0] exp_sts(int m);
        case (m)
            M_ACT:   return 4'b0001;
            M_RT:    return 4'b1011;
            M_LR:    return 4'b1001;
            M_LE:    return 4'b1010;
            M_DIS:   return 4'b1100;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic chk(string tag, int obs, int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic [3:0] req;
        req = rdi.lp_state_req;
        m_terr = 0;
        m_err  = 0;
        if (i_rst) begin
            m_mode = M_RST;
            m_left = 0;
            m_pres = 0;
            m_rc   = 0;
            m_spd  = '0;
            m_lnk  = '0;
        end else if (m_mode != M_LE && rdi.lp_linkerror) begin
            m_mode = M_LE;
            m_err  = 1;
            m_pres = 0;
            m_rc   = 0;
        end else begin
            case (m_mode)
                M_RST: begin
                    if (start) begin
                        m_mode = M_TR;
                        m_left = TC;
                    end else if (m_pres && req == REQ_ACTIVE) begin
                        m_mode = M_ACT;
                    end
                end
                M_TR: begin
                    if (fail) begin
                        m_mode = M_LE;
                        m_terr = 1;
                        m_err  = 1;
                        m_pres = 0;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_mode = M_RST;
                            m_pres = 1;
                            m_spd  = cfg_spd;
                            m_lnk  = cfg_lnk;
                        end
                    end
                end
                M_ACT: begin
                    if (req == REQ_RETRAIN || rec) begin
                        m_mode = M_RT;
                        m_left = RC;
                        m_rc   = 1;
                    end else if (req == REQ_LINKRESET) begin
                        m_mode = M_LR;
                        m_left = RC;
                    end else if (req == REQ_DISABLED) begin
                        m_mode = M_DIS;
                    end
                end
                M_RT: begin
                    if (m_rc) begin
                        m_left--;
                        if (m_left == 0) m_rc = 0;
                    end else if (req == REQ_ACTIVE) begin
                        m_mode = M_ACT;
                    end
                end
                M_LR: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = M_RST;
                        m_pres = 0;
                    end
                end
                M_DIS: begin
                    if (start) begin
                        m_mode = M_TR;
                        m_left = TC;
                        m_pres = 0;
                    end
                end
                M_LE: begin
                    if (!rdi.lp_linkerror && req == REQ_ACTIVE) begin
                        m_mode = M_RST;
                    end
                end
                default: m_mode = M_RST;
            endcase
        end
    endtask

    task automatic check_all();
        chk("sts", int'(rdi.pl_state_sts), int'(exp_sts(m_mode)));
        chk("inband_pres", int'(rdi.pl_inband_pres), int'(m_pres));
        chk("speedmode", int'(rdi.pl_speedmode), int'(m_spd));
        chk("lnk_cfg", int'(rdi.pl_lnk_cfg), int'(m_lnk));
        chk("phyinrecenter", int'(rdi.pl_phyinrecenter), int'(m_rc));
        chk("trainerror", int'(rdi.pl_trainerror), int'(m_terr));
        chk("error", int'(rdi.pl_error), int'(m_err));
    endtask

    task automatic step();
        model_update();
        @(posedge i_clk);
        #1;
        check_all();
    endtask

    task automatic train_up();
        rdi.lp_state_req = REQ_ACTIVE;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (TC + 1) step();
        chk("trained_active", int'(rdi.pl_state_sts), 1);
    endtask

    initial begin
        int n;
        int r;
        rdi.lp_state_req = REQ_NOP;
        rdi.lp_linkerror = 1'b0;

        // Reset values
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        step();
        chk("rst_sts", int'(rdi.pl_state_sts), 0);
        chk("rst_pres", int'(rdi.pl_inband_pres), 0);

        // Training success with Active held
        rdi.lp_state_req = REQ_ACTIVE;
        cfg_spd = 3'd5;
        cfg_lnk = 3'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (TC - 1) step();
        chk("train_last_pres", int'(rdi.pl_inband_pres), 0);
        step();
        chk("train_pres", int'(rdi.pl_inband_pres), 1);
        chk("train_spd", int'(rdi.pl_speedmode), 5);
        chk("train_lnk", int'(rdi.pl_lnk_cfg), 2);
        chk("train_sts_rst", int'(rdi.pl_state_sts), 0);
        cfg_spd = 3'd1;
        cfg_lnk = 3'd6;
        step();
        chk("active_sts", int'(rdi.pl_state_sts), 1);
        chk("active_spd_held", int'(rdi.pl_speedmode), 5);

        // Retrain request and recenter together: one retrain
        rdi.lp_state_req = REQ_RETRAIN;
        rec = 1'b1;
        step();
        rec = 1'b0;
        rdi.lp_state_req = REQ_ACTIVE;
        chk("retrain_sts", int'(rdi.pl_state_sts), 4'hb);
        n = int'(rdi.pl_phyinrecenter);
        repeat (30) begin
            step();
            n += int'(rdi.pl_phyinrecenter);
        end
        chk("recenter_len", n, RC);
        chk("retrain_exit", int'(rdi.pl_state_sts), 1);

        // LinkReset
        rdi.lp_state_req = REQ_LINKRESET;
        n = 0;
        repeat (20) begin
            step();
            if (rdi.pl_state_sts == STS_LINKRESET) n++;
        end
        chk("linkreset_len", n, RC);
        chk("linkreset_sts", int'(rdi.pl_state_sts), 0);
        chk("linkreset_pres", int'(rdi.pl_inband_pres), 0);

        // Link error during retrain
        train_up();
        rdi.lp_state_req = REQ_RETRAIN;
        step();
        rdi.lp_state_req = REQ_ACTIVE;
        repeat (4) step();
        rdi.lp_linkerror = 1'b1;
        step();
        chk("lerr_sts", int'(rdi.pl_state_sts), 4'ha);
        chk("lerr_pulse", int'(rdi.pl_error), 1);
        step();
        chk("lerr_pulse_end", int'(rdi.pl_error), 0);
        rdi.lp_linkerror = 1'b0;
        rdi.lp_state_req = REQ_NOP;
        step();
        chk("lerr_hold", int'(rdi.pl_state_sts), 4'ha);
        rdi.lp_state_req = REQ_ACTIVE;
        step();
        chk("lerr_exit", int'(rdi.pl_state_sts), 0);

        // Training failure at cycle 10
        rdi.lp_state_req = REQ_NOP;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        fail = 1'b1;
        step();
        fail = 1'b0;
        chk("tfail_sts", int'(rdi.pl_state_sts), 4'ha);
        chk("tfail_terr", int'(rdi.pl_trainerror), 1);
        chk("tfail_err", int'(rdi.pl_error), 1);
        chk("tfail_pres", int'(rdi.pl_inband_pres), 0);
        step();
        chk("tfail_terr_end", int'(rdi.pl_trainerror), 0);
        rdi.lp_state_req = REQ_ACTIVE;
        step();

        // Disabled is sticky until phy start; reset aborts training
        train_up();
        rdi.lp_state_req = REQ_DISABLED;
        step();
        chk("dis_sts", int'(rdi.pl_state_sts), 4'hc);
        rdi.lp_state_req = REQ_ACTIVE;
        repeat (5) step();
        chk("dis_sticky", int'(rdi.pl_state_sts), 4'hc);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("dis_exit_sts", int'(rdi.pl_state_sts), 0);
        chk("dis_exit_pres", int'(rdi.pl_inband_pres), 0);
        repeat (5) step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("midrst_spd", int'(rdi.pl_speedmode), 0);
        chk("midrst_lnk", int'(rdi.pl_lnk_cfg), 0);
        repeat (TC + 2) step();
        chk("midrst_no_train", int'(rdi.pl_inband_pres), 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55)      rdi.lp_state_req = REQ_ACTIVE;
            else if (r < 65) rdi.lp_state_req = REQ_NOP;
            else if (r < 73) rdi.lp_state_req = REQ_RETRAIN;
            else if (r < 79) rdi.lp_state_req = REQ_LINKRESET;
            else if (r < 83) rdi.lp_state_req = REQ_DISABLED;
            else if (r < 86) rdi.lp_state_req = REQ_L1;
            else             rdi.lp_state_req = REQ_ACTIVE;
            rdi.lp_linkerror = ($urandom_range(0, 199) == 0);
            start   = ($urandom_range(0, 29) == 0);
            fail    = ($urandom_range(0, 299) == 0);
            rec     = ($urandom_range(0, 29) == 0);
            i_rst   = ($urandom_range(0, 999) == 0);
            cfg_spd = 3'($urandom_range(0, 7));
            cfg_lnk = 3'($urandom_range(0, 7));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
